// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bus master: command op codes, FSM states
// and the peripheral register map it is normally pointed at.
package mmio_pkg;

  typedef enum logic [1:0] {
    OP_WR   = 2'b00,
    OP_RD   = 2'b01,
    OP_POLL = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    POLL_RD,
    POLL_WAIT,
    RESP
  } state_e;

  localparam logic [31:0] ADDR_TH         = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL         = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON       = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED        = 32'h4000_000C;
  localparam logic [31:0] ADDR_SWITCH     = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI       = 32'h4000_0014;
  localparam logic [31:0] ADDR_UART_A     = 32'h4000_0018;
  localparam logic [31:0] ADDR_UART_B     = 32'h4000_001C;
  localparam logic [31:0] ADDR_UART_READY = 32'h4000_0020;
  localparam logic [31:0] ADDR_RESULT     = 32'h4000_0024;
  localparam logic [31:0] ADDR_TX_EN      = 32'h4000_0028;

endpackage

// File: rtl/mmio_bus_master.sv
// Word-level bus initiator: single writes, incrementing read bursts and
// masked poll-until-match reads with a timeout, one response per word.
module mmio_bus_master
  import mmio_pkg::*;
#(
  parameter int POLL_MAX = 256,
  parameter int POLL_GAP = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [31:0] cmd_mask,
  input  logic [7:0]  cmd_count,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mask_q, mask_d;
  logic [7:0]  remaining_q, remaining_d;
  logic [31:0] tries_q, tries_d;
  logic [31:0] gap_q, gap_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_last_q, rsp_last_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;
  assign bus_rd    = (state_q == READ) || (state_q == POLL_RD);
  assign bus_wr    = (state_q == WRITE);
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  // Register all FSM state, counters and held response/bus values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_WR;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      remaining_q <= '0;
      tries_q     <= '0;
      gap_q       <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      remaining_q <= remaining_d;
      tries_q     <= tries_d;
      gap_q       <= gap_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Next-state, counter and response logic; the bus address/data registers
  // only move when a strobe state is entered so they hold between strobes.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    remaining_d = remaining_q;
    tries_d     = tries_q;
    gap_d       = gap_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    rsp_err_d   = rsp_err_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d        = op_e'(cmd_op);
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          mask_d      = cmd_mask;
          remaining_d = (cmd_count == 8'd0) ? 8'd1 : cmd_count;
          tries_d     = '0;
          gap_d       = '0;
          case (cmd_op)
            OP_WR:   state_d = WRITE;
            OP_RD:   state_d = READ;
            OP_POLL: state_d = POLL_RD;
            default: begin
              state_d    = RESP;
              rsp_data_d = '0;
              rsp_err_d  = 1'b1;
              rsp_last_d = 1'b1;
            end
          endcase
        end
      end
      WRITE: begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        rsp_last_d = 1'b1;
        state_d    = RESP;
      end
      READ: begin
        rsp_data_d = bus_rdata;
        rsp_err_d  = 1'b0;
        rsp_last_d = (remaining_q == 8'd1);
        state_d    = RESP;
      end
      POLL_RD: begin
        tries_d    = tries_q + 32'd1;
        rsp_data_d = bus_rdata;
        rsp_last_d = 1'b1;
        rsp_err_d  = 1'b0;
        if ((bus_rdata & mask_q) == (wdata_q & mask_q)) begin
          state_d = RESP;
        end else if (tries_q + 32'd1 == 32'(POLL_MAX)) begin
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end else if (POLL_GAP == 0) begin
          state_d = POLL_RD;
        end else begin
          gap_d   = '0;
          state_d = POLL_WAIT;
        end
      end
      POLL_WAIT: begin
        if (gap_q == 32'(POLL_GAP - 1)) begin
          state_d = POLL_RD;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (op_q == OP_RD && remaining_q > 8'd1) begin
            remaining_d = remaining_q - 8'd1;
            addr_d      = addr_q + 32'd4;
            state_d     = READ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == WRITE || state_d == READ || state_d == POLL_RD) begin
      bus_addr_d = addr_d;
    end
    if (state_d == WRITE) begin
      bus_wdata_d = wdata_d;
    end
  end

endmodule

// File: tb/tb_mmio_bus_master.sv
// Self-checking bench for mmio_bus_master against a small peripheral model.
module tb_mmio_bus_master;
  import mmio_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, cmd_mask = '0;
  logic [7:0]  cmd_count = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_last, rsp_err;
  logic [31:0] rsp_data;
  logic        bus_rd, bus_wr;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  logic        p4_cmd_valid = 1'b0, p4_cmd_ready;
  logic [1:0]  p4_cmd_op = '0;
  logic [31:0] p4_cmd_addr = '0, p4_cmd_wdata = '0, p4_cmd_mask = '0;
  logic [7:0]  p4_cmd_count = '0;
  logic        p4_rsp_valid, p4_rsp_ready = 1'b0, p4_rsp_last, p4_rsp_err;
  logic [31:0] p4_rsp_data;
  logic        p4_bus_rd, p4_bus_wr;
  logic [31:0] p4_bus_addr, p4_bus_wdata;
  logic [31:0] p4_bus_rdata = '0;

  int tests = 0;
  int failures = 0;
  int cyc = 0;
  int rd_count = 0, wr_count = 0, both_hi = 0, p4_rd_count = 0;
  logic [31:0] rd_addrs[$];
  int          rd_times[$];
  logic [31:0] wr_addr_seen = '0;
  logic [31:0] mem[16];
  logic        uart_ready = 1'b0;

  always #5 clk = ~clk;

  mmio_bus_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .cmd_count(cmd_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  mmio_bus_master #(.POLL_MAX(4), .POLL_GAP(2)) dut4 (
    .clk(clk), .reset(reset),
    .cmd_valid(p4_cmd_valid), .cmd_ready(p4_cmd_ready), .cmd_op(p4_cmd_op),
    .cmd_addr(p4_cmd_addr), .cmd_wdata(p4_cmd_wdata), .cmd_mask(p4_cmd_mask),
    .cmd_count(p4_cmd_count),
    .rsp_valid(p4_rsp_valid), .rsp_ready(p4_rsp_ready), .rsp_data(p4_rsp_data),
    .rsp_last(p4_rsp_last), .rsp_err(p4_rsp_err),
    .bus_rd(p4_bus_rd), .bus_wr(p4_bus_wr), .bus_addr(p4_bus_addr),
    .bus_wdata(p4_bus_wdata), .bus_rdata(p4_bus_rdata)
  );

  // Peripheral model: register file at 0x400000xx, UART_READY from the bench,
  // anything else returns a pattern derived from the address.
  always_comb begin
    if (bus_addr[31:8] == 24'h40_0000) begin
      if (bus_addr[7:0] == 8'h20) bus_rdata = {31'b0, uart_ready};
      else                        bus_rdata = mem[bus_addr[5:2]];
    end else begin
      bus_rdata = bus_addr ^ 32'hDEAD_BEEF;
    end
  end

  // Peripheral register writes.
  always @(posedge clk) begin
    if (bus_wr) mem[bus_addr[5:2]] <= bus_wdata;
  end

  // Bus monitor: counts strobes and records read addresses and times.
  always @(negedge clk) begin
    cyc++;
    if (bus_rd) begin
      rd_count++;
      rd_addrs.push_back(bus_addr);
      rd_times.push_back(cyc);
    end
    if (bus_wr) begin
      wr_count++;
      wr_addr_seen = bus_addr;
    end
    if (bus_rd && bus_wr) both_hi++;
    if (p4_bus_rd) p4_rd_count++;
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mask;
    logic [7:0]  count;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        exp_last;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[9];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] mask,
                                input logic [7:0] count);
    @(negedge clk);
    check_output("cmd_ready idle", {63'b0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_mask  = mask;
    cmd_count = count;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output logic [31:0] d, output logic l, output logic e);
    int n = 0;
    while (!rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      tests++;
      failures++;
      $display("[TB] FAIL rsp timeout: got no rsp_valid, expected one within %0d cycles", budget);
      d = 'x;
      l = 1'bx;
      e = 1'bx;
    end else begin
      d = rsp_data;
      l = rsp_last;
      e = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        l, e;
    int          rd0, wr0;

    for (int i = 0; i < 16; i++) mem[i] = '0;

    vecs[0] = '{OP_WR,  ADDR_LED,  32'hA5, 32'h0, 8'd1, 32'h0,  1'b0, 1'b1, 0, 1, ADDR_LED};
    vecs[1] = '{OP_WR,  ADDR_TH,   32'h11, 32'h0, 8'd1, 32'h0,  1'b0, 1'b1, 0, 1, ADDR_TH};
    vecs[2] = '{OP_WR,  ADDR_TL,   32'h22, 32'h0, 8'd1, 32'h0,  1'b0, 1'b1, 0, 1, ADDR_TL};
    vecs[3] = '{OP_WR,  ADDR_TCON, 32'h3,  32'h0, 8'd1, 32'h0,  1'b0, 1'b1, 0, 1, ADDR_TCON};
    vecs[4] = '{OP_RD,  ADDR_LED,  32'h0,  32'h0, 8'd1, 32'hA5, 1'b0, 1'b1, 1, 0, ADDR_LED};
    vecs[5] = '{OP_RD,  ADDR_TL,   32'h0,  32'h0, 8'd0, 32'h22, 1'b0, 1'b1, 1, 0, ADDR_TL};
    vecs[6] = '{OP_RSV, ADDR_TH,   32'h0,  32'h0, 8'd1, 32'h0,  1'b1, 1'b1, 0, 0, 32'h0};
    vecs[7] = '{OP_POLL, ADDR_LED, 32'hA0, 32'hF0, 8'd1, 32'hA5, 1'b0, 1'b1, 1, 0, ADDR_LED};
    vecs[8] = '{OP_RD, 32'h1234_5671, 32'h0, 32'h0, 8'd1, 32'hCC99_E89E, 1'b0, 1'b1, 1, 0, 32'h1234_5671};

    // Reset state: everything 0, cmd_ready held low while reset is high.
    repeat (3) @(negedge clk);
    check_output("reset ctrl", {58'b0, cmd_ready, rsp_valid, bus_rd, bus_wr, rsp_last, rsp_err}, 64'd0);
    check_output("reset bus_addr", {32'b0, bus_addr}, 64'd0);
    check_output("reset rsp_data", {32'b0, rsp_data}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_output("cmd_ready after reset", {63'b0, cmd_ready}, 64'd1);

    // Single-response commands from the table.
    for (int i = 0; i < 9; i++) begin
      rd0 = rd_count;
      wr0 = wr_count;
      rd_addrs.delete();
      apply_stimulus(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].mask, vecs[i].count);
      check_output($sformatf("v%0d strobe", i), {62'b0, bus_rd, bus_wr},
                   {62'b0, vecs[i].exp_rd > 0, vecs[i].exp_wr > 0});
      check_output($sformatf("v%0d early rsp_valid", i), {63'b0, rsp_valid},
                   {63'b0, vecs[i].op == OP_RSV});
      wait_rsp(20, d, l, e);
      @(negedge clk);
      check_output($sformatf("v%0d rsp_data", i), {32'b0, d}, {32'b0, vecs[i].exp_data});
      check_output($sformatf("v%0d rsp_err/last", i), {62'b0, e, l},
                   {62'b0, vecs[i].exp_err, vecs[i].exp_last});
      check_output($sformatf("v%0d rd count", i), 64'(rd_count - rd0), 64'(vecs[i].exp_rd));
      check_output($sformatf("v%0d wr count", i), 64'(wr_count - wr0), 64'(vecs[i].exp_wr));
      if (vecs[i].exp_rd > 0 && rd_addrs.size() > 0)
        check_output($sformatf("v%0d rd addr", i), {32'b0, rd_addrs[$]}, {32'b0, vecs[i].exp_addr});
      if (vecs[i].exp_wr > 0)
        check_output($sformatf("v%0d wr addr", i), {32'b0, wr_addr_seen}, {32'b0, vecs[i].exp_addr});
    end
    check_output("led register", {32'b0, mem[3]}, 64'hA5);

    // Read burst of 3 over TH/TL/TCON; last only on the third word.
    rd0 = rd_count;
    rd_addrs.delete();
    apply_stimulus(OP_RD, ADDR_TH, 32'h0, 32'h0, 8'd3);
    wait_rsp(20, d, l, e);
    check_output("burst w0", {31'b0, d, l}, {31'b0, 32'h11, 1'b0});
    wait_rsp(20, d, l, e);
    check_output("burst w1", {31'b0, d, l}, {31'b0, 32'h22, 1'b0});
    wait_rsp(20, d, l, e);
    check_output("burst w2", {31'b0, d, l}, {31'b0, 32'h3, 1'b1});
    @(negedge clk);
    check_output("burst rd count", 64'(rd_count - rd0), 64'd3);
    if (rd_addrs.size() == 3) begin
      check_output("burst addr1", {32'b0, rd_addrs[1]}, {32'b0, ADDR_TL});
      check_output("burst addr2", {32'b0, rd_addrs[2]}, {32'b0, ADDR_TCON});
    end

    // Poll UART_READY; ready rises ~40 cycles in, reads spaced 16 apart.
    rd0 = rd_count;
    rd_times.delete();
    uart_ready = 1'b0;
    apply_stimulus(OP_POLL, ADDR_UART_READY, 32'h1, 32'h1, 8'd1);
    for (int k = 0; k < 200 && !rsp_valid; k++) begin
      if (k == 38) uart_ready = 1'b1;
      @(negedge clk);
    end
    wait_rsp(1, d, l, e);
    @(negedge clk);
    check_output("poll data", {32'b0, d}, 64'h1);
    check_output("poll err/last", {62'b0, e, l}, 64'b01);
    check_output("poll rd count", 64'(rd_count - rd0), 64'd4);
    if (rd_times.size() == 4) begin
      check_output("poll gap 1", 64'(rd_times[1] - rd_times[0]), 64'd16);
      check_output("poll gap 3", 64'(rd_times[3] - rd_times[2]), 64'd16);
    end
    uart_ready = 1'b0;

    // Poll timeout on the POLL_MAX=4 instance: exactly 4 reads then err.
    @(negedge clk);
    p4_cmd_valid = 1'b1;
    p4_cmd_op    = OP_POLL;
    p4_cmd_addr  = ADDR_UART_READY;
    p4_cmd_wdata = 32'h1;
    p4_cmd_mask  = 32'h1;
    @(negedge clk);
    p4_cmd_valid = 1'b0;
    for (int k = 0; k < 100 && !p4_rsp_valid; k++) @(negedge clk);
    check_output("timeout rsp", {29'b0, p4_rsp_valid, p4_rsp_err, p4_rsp_last, p4_rsp_data},
                 {29'b0, 1'b1, 1'b1, 1'b1, 32'h0});
    p4_rsp_ready = 1'b1;
    @(negedge clk);
    p4_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_output("timeout rd count", 64'(p4_rd_count), 64'd4);

    // Backpressure and wrap: count 2 at 0xFFFFFFFC, hold off 10 cycles.
    rd0 = rd_count;
    rd_addrs.delete();
    apply_stimulus(OP_RD, 32'hFFFF_FFFC, 32'h0, 32'h0, 8'd2);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check_output($sformatf("stall %0d", k), {29'b0, rsp_valid, bus_rd, rsp_last, rsp_data},
                   {29'b0, 1'b1, 1'b0, 1'b0, 32'h2152_4113});
      @(negedge clk);
    end
    check_output("stall rd count", 64'(rd_count - rd0), 64'd1);
    wait_rsp(1, d, l, e);
    wait_rsp(20, d, l, e);
    check_output("wrap w1", {31'b0, d, l}, {31'b0, 32'hDEAD_BEEF, 1'b1});
    @(negedge clk);
    if (rd_addrs.size() == 2)
      check_output("wrap addr", {32'b0, rd_addrs[1]}, 64'h0);
    else
      check_output("wrap rd count", 64'(rd_addrs.size()), 64'd2);

    // Reset after the second response of a 5-word burst.
    rd0 = rd_count;
    apply_stimulus(OP_RD, ADDR_TH, 32'h0, 32'h0, 8'd5);
    wait_rsp(20, d, l, e);
    wait_rsp(20, d, l, e);
    check_output("pre-reset w1", {32'b0, d}, 64'h22);
    reset = 1'b1;
    @(negedge clk);
    check_output("mid reset ctrl", {58'b0, cmd_ready, rsp_valid, bus_rd, bus_wr, rsp_last, rsp_err}, 64'd0);
    check_output("mid reset data", {bus_addr, rsp_data}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_output("cmd_ready post reset", {62'b0, cmd_ready, rsp_valid}, 64'b10);
    repeat (10) @(negedge clk);
    check_output("reset rd count", 64'(rd_count - rd0), 64'd3);

    check_output("rd/wr exclusive", 64'(both_hi), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
